branch_predictor_btb: RTL and testbench

BRANCH_PREDICTOR_BTB -- requirements
Module: branch_predictor_btb

---
 rtl/lc3b_types.sv | 20 ++
 rtl/sat_counter.sv | 28 ++
 rtl/branch_predictor_btb.sv | 135 +++++++++++++
 tb/tb_branch_predictor_btb.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared BTB types: the per-entry record and the default table depth.
package lc3b_types;

  localparam int BP_DEFAULT_ENTRIES = 16;
  localparam int BP_TAG_MAX         = 13;
  localparam int BP_CTR_MAX         = 4;

  // Fields are sized for the smallest table and widest counter; narrower configs zero-extend.
  typedef struct packed {
    logic                  valid;
    logic [BP_TAG_MAX-1:0] tag;
    logic [15:0]           target;
    logic [BP_CTR_MAX-1:0] counter;
  } lc3b_bp_entry;

  function automatic logic [15:0] pc_plus2(input logic [15:0] pc);
    return pc + 16'd2;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Next-value logic for one saturating direction counter; purely combinational.
// Priority: set-max, then set-weak (MSB only), then increment, then decrement.
module sat_counter #(
  parameter int W = 2
) (
  input  logic [W-1:0] cnt_i,
  input  logic         inc_i,
  input  logic         dec_i,
  input  logic         set_max_i,
  input  logic         set_weak_i,
  output logic [W-1:0] cnt_o
);

  always_comb begin
    cnt_o = cnt_i;
    if (set_max_i) begin
      cnt_o = '1;
    end else if (set_weak_i) begin
      cnt_o        = '0;
      cnt_o[W-1]   = 1'b1;
    end else if (inc_i && (cnt_i != '1)) begin
      cnt_o = cnt_i + 1'b1;
    end else if (dec_i && (cnt_i != '0)) begin
      cnt_o = cnt_i - 1'b1;
    end
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with saturating direction counters: zero-latency lookup, update at next edge.
// Optional statistics counters under BP_STATS_EN; no backpressure, stall suppresses updates.
module branch_predictor_btb
  import lc3b_types::*;
#(
  parameter int ENTRIES   = BP_DEFAULT_ENTRIES,
  parameter int CTR_WIDTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] fetch_pc,
  output logic        pred_taken,
  output logic [15:0] pred_target,
  input  logic        stall,
  input  logic        upd_valid,
  input  logic        upd_uncond,
  input  logic [15:0] upd_pc,
  input  logic        upd_taken,
  input  logic [15:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [15:0] upd_pred_target,
  output logic        mispredict,
  output logic [15:0] redirect_pc,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);

  localparam int IDX = $clog2(ENTRIES);

  lc3b_bp_entry tbl_q [ENTRIES];

  logic [IDX-1:0]        f_idx;
  logic [BP_TAG_MAX-1:0] f_tag;
  lc3b_bp_entry          f_ent;
  logic                  f_hit;

  logic [IDX-1:0]        u_idx;
  logic [BP_TAG_MAX-1:0] u_tag;
  lc3b_bp_entry          u_ent;
  logic                  u_hit;
  logic                  upd;
  logic                  tbl_we;
  logic [CTR_WIDTH-1:0]  ctr_d;
  lc3b_bp_entry          ent_d;
  logic                  unused_ctr_hi;

  // Lookup: fetch side reads pre-update contents, no bypass from the update port.
  assign f_idx       = fetch_pc[IDX:1];
  assign f_tag       = BP_TAG_MAX'(fetch_pc[15:IDX+1]);
  assign f_ent       = tbl_q[f_idx];
  assign f_hit       = f_ent.valid && (f_ent.tag == f_tag);
  assign pred_taken  = f_hit && f_ent.counter[CTR_WIDTH-1];
  assign pred_target = pred_taken ? f_ent.target : pc_plus2(fetch_pc);

  assign u_idx = upd_pc[IDX:1];
  assign u_tag = BP_TAG_MAX'(upd_pc[15:IDX+1]);
  assign u_ent = tbl_q[u_idx];
  assign u_hit = u_ent.valid && (u_ent.tag == u_tag);
  assign upd   = upd_valid && !stall;

  assign mispredict  = upd && ((upd_taken != upd_pred_taken) ||
                               (upd_taken && (upd_target != upd_pred_target)));
  assign redirect_pc = upd_taken ? upd_target : pc_plus2(upd_pc);

  assign unused_ctr_hi = ^{f_ent.counter, u_ent.counter};

  sat_counter #(.W(CTR_WIDTH)) u_ctr (
    .cnt_i      (u_ent.counter[CTR_WIDTH-1:0]),
    .inc_i      (u_hit && upd_taken),
    .dec_i      (u_hit && !upd_taken),
    .set_max_i  (upd_uncond),
    .set_weak_i (!u_hit && upd_taken),
    .cnt_o      (ctr_d)
  );

  // A not-taken miss leaves the table alone; everything else writes the indexed entry.
  assign tbl_we = upd && (u_hit || upd_taken);

  always_comb begin
    ent_d                         = u_ent;
    ent_d.counter                 = '0;
    ent_d.counter[CTR_WIDTH-1:0]  = ctr_d;
    if (upd_taken) begin
      ent_d.target = upd_target;
    end
    if (!u_hit) begin
      ent_d.valid = 1'b1;
      ent_d.tag   = u_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_q[i].valid   <= 1'b0;
        tbl_q[i].counter <= '0;
      end
    end else if (tbl_we) begin
      tbl_q[u_idx] <= ent_d;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] stat_br_q, stat_br_d;
  logic [31:0] stat_mp_q, stat_mp_d;

  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (upd) begin
      stat_br_d = stat_br_q + 32'd1;
      if (mispredict) begin
        stat_mp_d = stat_mp_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Scoreboarded bench for branch_predictor_btb: directed scenarios then random traffic vs a table model.
module tb_branch_predictor_btb;

  localparam int ENT  = 16;
  localparam int CW   = 2;
  localparam int IDXB = $clog2(ENT);
  localparam int CMAX = (1 << CW) - 1;
  localparam int WEAK = 1 << (CW - 1);

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] fetch_pc;
  logic        pred_taken;
  logic [15:0] pred_target;
  logic        stall;
  logic        upd_valid;
  logic        upd_uncond;
  logic [15:0] upd_pc;
  logic        upd_taken;
  logic [15:0] upd_target;
  logic        upd_pred_taken;
  logic [15:0] upd_pred_target;
  logic        mispredict;
  logic [15:0] redirect_pc;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  always #5 clk = ~clk;

  branch_predictor_btb #(.ENTRIES(ENT), .CTR_WIDTH(CW)) dut (
    .clk              (clk),
    .rst              (rst),
    .fetch_pc         (fetch_pc),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .stall            (stall),
    .upd_valid        (upd_valid),
    .upd_uncond       (upd_uncond),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_pred_taken   (upd_pred_taken),
    .upd_pred_target  (upd_pred_target),
    .mispredict       (mispredict),
    .redirect_pc      (redirect_pc),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  typedef struct {
    logic        pt;
    logic [15:0] ptgt;
    logic        mp;
    logic [15:0] rd;
    logic [31:0] sb;
    logic [31:0] sm;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: one record per table slot, counters kept as plain integers.
  bit          mv   [ENT];
  int          mtag [ENT];
  logic [15:0] mtgt [ENT];
  int          mctr [ENT];
  logic [31:0] mb = '0;
  logic [31:0] mm = '0;
  bit          known = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic bit m_pred(input logic [15:0] pc, output logic [15:0] tgt);
    int i;
    int t;
    bit h;
    bit p;
    i   = int'(pc >> 1) % ENT;
    t   = int'(pc >> (IDXB + 1));
    h   = mv[i] && (mtag[i] == t);
    p   = h && (mctr[i] >= WEAK);
    tgt = p ? mtgt[i] : 16'(pc + 16'd2);
    return p;
  endfunction

  task automatic set_in(input bit r, input bit st, input logic [15:0] fpc,
                        input bit uv, input bit uu, input logic [15:0] upc,
                        input bit ut, input logic [15:0] utgt,
                        input bit upt, input logic [15:0] uptgt);
    exp_t e;
    bit   upd;
    bit   mis;
    int   i;
    int   t;
    rst = r; stall = st; fetch_pc = fpc; upd_valid = uv; upd_uncond = uu;
    upd_pc = upc; upd_taken = ut; upd_target = utgt;
    upd_pred_taken = upt; upd_pred_target = uptgt;

    upd  = uv && !st;
    mis  = upd && ((ut != upt) || (ut && (utgt != uptgt)));
    e.pt = m_pred(fpc, e.ptgt);
    e.mp = mis;
    e.rd = ut ? utgt : 16'(upc + 16'd2);
`ifdef BP_STATS_EN
    e.sb = mb;
    e.sm = mm;
`else
    e.sb = '0;
    e.sm = '0;
`endif
    if (known) q.push_back(e);

    if (r) begin
      for (int k = 0; k < ENT; k++) begin
        mv[k]   = 1'b0;
        mctr[k] = 0;
      end
      mb    = '0;
      mm    = '0;
      known = 1'b1;
    end else if (upd) begin
      mb++;
      if (mis) mm++;
      i = int'(upc >> 1) % ENT;
      t = int'(upc >> (IDXB + 1));
      if (mv[i] && (mtag[i] == t)) begin
        if (uu)      mctr[i] = CMAX;
        else if (ut) mctr[i] = (mctr[i] < CMAX) ? mctr[i] + 1 : CMAX;
        else         mctr[i] = (mctr[i] > 0) ? mctr[i] - 1 : 0;
        if (ut) mtgt[i] = utgt;
      end else if (ut) begin
        mv[i]   = 1'b1;
        mtag[i] = t;
        mtgt[i] = utgt;
        mctr[i] = uu ? CMAX : WEAK;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [15:0] fpc);
    set_in(1'b0, 1'b0, fpc, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
  endtask

  // Monitor: outputs are combinational, so one expectation is due every cycle on the falling edge.
  always @(negedge clk) begin : mon
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("sb_pred_taken",  32'(pred_taken),  32'(e.pt));
      chk("sb_pred_target", 32'(pred_target), 32'(e.ptgt));
      chk("sb_mispredict",  32'(mispredict),  32'(e.mp));
      chk("sb_redirect_pc", 32'(redirect_pc), 32'(e.rd));
      chk("sb_stat_branches",    stat_branches,    e.sb);
      chk("sb_stat_mispredicts", stat_mispredicts, e.sm);
    end
  end

  initial begin : stim
    logic [15:0] fpc, upc, utgt, uptgt;
    bit          r, st, uv, uu, ut, upt;

    set_in(1'b1, 1'b0, 16'h3000, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
    tick();

    idle(16'h3000);
    #1;
    chk("rst_pred_taken",  32'(pred_taken),  32'h0);
    chk("rst_pred_target", 32'(pred_target), 32'h3002);
    chk("rst_mispredict",  32'(mispredict),  32'h0);
    tick();

    set_in(1'b0, 1'b0, 16'h3000, 1'b1, 1'b0, 16'h3000, 1'b1, 16'h3040, 1'b0, 16'h3002);
    #1;
    chk("first_taken_mispredict", 32'(mispredict),  32'h1);
    chk("first_taken_redirect",   32'(redirect_pc), 32'h3040);
    chk("no_bypass_pred_taken",   32'(pred_taken),  32'h0);
    tick();
    idle(16'h3000);
    #1;
    chk("alloc_pred_taken",  32'(pred_taken),  32'h1);
    chk("alloc_pred_target", 32'(pred_target), 32'h3040);
    tick();

    // Drive the counter down to zero, then back up one step at a time.
    repeat (3) begin
      upt = m_pred(16'h3000, uptgt);
      set_in(1'b0, 1'b0, 16'h3000, 1'b1, 1'b0, 16'h3000, 1'b0, 16'h0, upt, uptgt);
      tick();
    end
    upt = m_pred(16'h3000, uptgt);
    set_in(1'b0, 1'b0, 16'h3000, 1'b1, 1'b0, 16'h3000, 1'b1, 16'h3040, upt, uptgt);
    tick();
    idle(16'h3000);
    #1;
    chk("ctr_one_not_taken", 32'(pred_taken), 32'h0);
    tick();
    upt = m_pred(16'h3000, uptgt);
    set_in(1'b0, 1'b0, 16'h3000, 1'b1, 1'b0, 16'h3000, 1'b1, 16'h3040, upt, uptgt);
    tick();
    idle(16'h3000);
    #1;
    chk("ctr_two_taken", 32'(pred_taken), 32'h1);
    tick();

    set_in(1'b0, 1'b0, 16'h3020, 1'b1, 1'b0, 16'h3020, 1'b1, 16'h3060, 1'b0, 16'h3022);
    tick();
    idle(16'h3000);
    #1;
    chk("alias_evict_target", 32'(pred_target), 32'h3002);
    tick();

    repeat (5) begin
      set_in(1'b1 & 1'b0, 1'b1, 16'h3000, 1'b1, 1'b0, 16'h3000, 1'b1, 16'h3080, 1'b0, 16'h3002);
      #1;
      chk("stall_mispredict", 32'(mispredict), 32'h0);
      tick();
    end
    idle(16'h3000);
    #1;
    chk("stall_no_change", 32'(pred_target), 32'h3002);
    tick();
    set_in(1'b0, 1'b0, 16'h3000, 1'b1, 1'b0, 16'h3000, 1'b1, 16'h3080, 1'b0, 16'h3002);
    tick();
    idle(16'h3000);
    #1;
    chk("after_stall_target", 32'(pred_target), 32'h3080);
    tick();

    set_in(1'b0, 1'b0, 16'hFFFE, 1'b1, 1'b0, 16'hFFFE, 1'b0, 16'h0, 1'b0, 16'h0);
    #1;
    chk("wrap_pred_target", 32'(pred_target), 32'h0000);
    chk("wrap_redirect",    32'(redirect_pc), 32'h0000);
    tick();

    set_in(1'b1, 1'b0, 16'h3000, 1'b1, 1'b1, 16'h3000, 1'b1, 16'h3040, 1'b0, 16'h3002);
    tick();
    idle(16'h3000);
    #1;
    chk("rst_wins_pred_taken", 32'(pred_taken), 32'h0);
    tick();

    for (int n = 0; n < 3000; n++) begin
      fpc  = 16'h3000 + 16'(2 * $urandom_range(0, 63));
      upc  = 16'h3000 + 16'(2 * $urandom_range(0, 63));
      r    = ($urandom_range(0, 199) == 0);
      st   = ($urandom_range(0, 9) < 2);
      uv   = ($urandom_range(0, 9) < 6);
      uu   = ($urandom_range(0, 6) == 0);
      ut   = uu ? 1'b1 : 1'($urandom_range(0, 1));
      utgt = 16'h4000 + 16'(2 * $urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) begin
        upt = m_pred(upc, uptgt);
      end else begin
        upt   = 1'($urandom_range(0, 1));
        uptgt = 16'h4000 + 16'(2 * $urandom_range(0, 7));
      end
      set_in(r, st, fpc, uv, uu, upc, ut, utgt, upt, uptgt);
      tick();
    end

    idle(16'h3000);
    tick();
    tick();
    chk("scoreboard_drained", 32'(q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
